vga_scanout: RTL and testbench

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout.sv | 192 +++++++++++++++++++
 tb/tb_vga_scanout.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// VGA scanout: h/v timing, letterbox borders, two-word framebuffer prefetch FIFO.
// Output latency PIPE_DEPTH clocks; fetch stalls while the FIFO is full, starvation blanks the pixel pair.
module vga_scanout #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int TOP_BORDER    = 40,
  parameter int BOTTOM_BORDER = 40,
  parameter int PIPE_DEPTH    = 3,
  parameter bit SYNC_ACTIVE   = 1'b0,
  parameter int ADDR_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              fb_access,
  output logic [ADDR_W-1:0] fb_address,
  input  logic              fb_ack,
  input  logic [15:0]       fb_data,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [7:0]        pix_idx,
  output logic              pix_valid,
  output logic              frame_start,
  output logic              underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int WORDS   = (H_ACTIVE / 2) * (V_ACTIVE - TOP_BORDER - BOTTOM_BORDER);
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int CW      = $clog2(WORDS + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_TOP  = VW'(TOP_BORDER);
  localparam logic [VW-1:0] V_BOT  = VW'(V_ACTIVE - BOTTOM_BORDER);
  localparam logic [CW-1:0] WORDS_C  = CW'(WORDS);
  localparam logic [CW-1:0] WORDS_M1 = CW'(WORDS - 1);

  typedef enum logic {IDLE, REQ} state_t;

  typedef struct packed {
    logic       frame_start;
    logic       hsync;
    logic       vsync;
    logic       valid;
    logic [7:0] idx;
  } pix_t;

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  state_t        state, state_nxt;
  logic [CW-1:0] fetch_cnt;
  logic          discard;
  logic [15:0]   fifo_mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    occ;
  logic          fifo_empty, fifo_full;
  logic          disp, odd, restart, push, pop, starve, pair_starved;
  pix_t          stage0;
  pix_t          pipe [PIPE_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign disp       = (h < H_ACT) && (v >= V_TOP) && (v < V_BOT);
  assign odd        = h[0];
  assign restart    = (h == '0) && (v == V_ACT);
  assign fifo_empty = (occ == 2'd0);
  assign fifo_full  = (occ == 2'd2);
  assign starve     = disp && !odd && fifo_empty;
  // A starved pair keeps its word in the FIFO; the next pair picks it up.
  assign pop        = disp && odd && !pair_starved;
  assign push       = (state == REQ) && fb_ack && !discard && !restart;
  assign fb_access  = (state == REQ);

  always_comb begin
    stage0             = '0;
    stage0.frame_start = (h == '0) && (v == '0);
    stage0.hsync       = (h >= HS_BEG) && (h < HS_END);
    stage0.vsync       = (v >= VS_BEG) && (v < VS_END);
    stage0.valid       = disp;
    if (disp && !(odd ? pair_starved : fifo_empty))
      stage0.idx = odd ? fifo_mem[rd_ptr][15:8] : fifo_mem[rd_ptr][7:0];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (!fifo_full && (fetch_cnt < WORDS_C)) state_nxt = REQ;
      REQ:  if (fb_ack) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A request still in flight at frame restart must keep its address until acked,
  // so the address rewind is deferred to that ack and its data dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt  <= '0;
      fb_address <= '0;
      discard    <= 1'b0;
    end else if (restart) begin
      fetch_cnt <= '0;
      if (state == REQ && !fb_ack) begin
        discard <= 1'b1;
      end else begin
        fb_address <= '0;
        discard    <= 1'b0;
      end
    end else if (state == REQ && fb_ack) begin
      if (discard) begin
        discard    <= 1'b0;
        fb_address <= '0;
      end else begin
        fetch_cnt <= fetch_cnt + 1'b1;
        if (fetch_cnt < WORDS_M1) fb_address <= fb_address + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= fb_data;
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pair_starved <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (disp && !odd) pair_starved <= fifo_empty;
      if (starve) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= stage0;
      for (int i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign vga_hsync   = pipe[PIPE_DEPTH-1].hsync ? SYNC_ACTIVE : !SYNC_ACTIVE;
  assign vga_vsync   = pipe[PIPE_DEPTH-1].vsync ? SYNC_ACTIVE : !SYNC_ACTIVE;
  assign pix_valid   = pipe[PIPE_DEPTH-1].valid;
  assign pix_idx     = pipe[PIPE_DEPTH-1].idx;
  assign frame_start = pipe[PIPE_DEPTH-1].frame_start;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout with small timing: framebuffer responder plus a queue-based scanout model.
module tb_vga_scanout;

  localparam int HA = 8, HF = 2, HSY = 2, HBP = 2;
  localparam int VA = 6, VFP = 1, VSY = 1, VBP = 1;
  localparam int TB = 1, BB = 1, PD = 3;
  localparam int HT = HA + HF + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int WORDS = (HA / 2) * (VA - TB - BB);
  localparam int PIX_PER_FRAME = HA * (VA - TB - BB);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fb_access;
  logic [15:0] fb_address;
  logic        fb_ack = 1'b0;
  logic [15:0] fb_data = 16'h0;
  logic        vga_hsync, vga_vsync;
  logic [7:0]  pix_idx;
  logic        pix_valid, frame_start, underflow;

  int n_total = 0;
  int n_pass  = 0;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .TOP_BORDER(TB), .BOTTOM_BORDER(BB), .PIPE_DEPTH(PD),
    .SYNC_ACTIVE(1'b0), .ADDR_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .fb_access(fb_access), .fb_address(fb_address), .fb_ack(fb_ack), .fb_data(fb_data),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .pix_idx(pix_idx), .pix_valid(pix_valid),
    .frame_start(frame_start), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       fs;
    logic       hs;
    logic       vs;
    logic       val;
    logic [7:0] idx;
  } exp_t;

  exp_t        hist[$];
  logic [15:0] wq[$];
  int          k, fetched, vcnt;
  bit          starved, uf_exp, discard_pend, req_open;
  logic [15:0] req_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total = n_total + 1;
    assert (obs === expv) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic model_reset();
    k = 0; fetched = 0; vcnt = 0;
    starved = 0; uf_exp = 0; discard_pend = 0; req_open = 0;
    req_addr = '0;
    hist.delete();
    wq.delete();
  endtask

  // One clock of checking and stimulus, entered and left at a falling edge.
  // mode 0: every request acked at once; mode 1: random acks, also while idle.
  task automatic step(input int mode);
    int   h, v;
    bit   disp, ack, rst_pos;
    exp_t e, o;
    h = k % HT;
    v = (k / HT) % VT;
    rst_pos = (h == 0) && (v == VA);

    o = '0;
    if (hist.size() == PD) o = hist.pop_front();
    chk("hsync", 32'(vga_hsync), o.hs ? 32'd0 : 32'd1);
    chk("vsync", 32'(vga_vsync), o.vs ? 32'd0 : 32'd1);
    chk("pix_valid", 32'(pix_valid), 32'(o.val));
    chk("pix_idx", 32'(pix_idx), 32'(o.idx));
    chk("frame_start", 32'(frame_start), 32'(o.fs));
    chk("underflow", 32'(underflow), 32'(uf_exp));
    if (k >= PD) begin
      vcnt += int'(pix_valid);
      if ((k - PD) % FRAME == FRAME - 1) begin
        chk("valid_per_frame", 32'(vcnt), 32'(PIX_PER_FRAME));
        vcnt = 0;
      end
    end

    if (fb_access) begin
      if (!req_open) begin
        req_open = 1;
        req_addr = fb_address;
        if (!discard_pend) begin
          chk("fetch_addr", 32'(fb_address), 32'(fetched));
          chk("fetch_gate", 32'(wq.size() < 2 && fetched < WORDS), 32'd1);
        end
      end else begin
        chk("addr_stable", 32'(fb_address), 32'(req_addr));
      end
    end

    e = '0;
    e.fs = (h == 0) && (v == 0);
    e.hs = (h >= HA + HF) && (h < HA + HF + HSY);
    e.vs = (v >= VA + VFP) && (v < VA + VFP + VSY);
    disp = (h < HA) && (v >= TB) && (v < VA - BB);
    e.val = disp;
    if (disp) begin
      if (h % 2 == 0) begin
        starved = (wq.size() == 0);
        if (starved) uf_exp = 1;
        else e.idx = wq[0][7:0];
      end else if (!starved) begin
        e.idx = wq[0][15:8];
        void'(wq.pop_front());
      end
    end
    hist.push_back(e);

    ack = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
    fb_ack  = ack;
    fb_data = 16'($urandom);
    if (rst_pos) begin
      wq.delete();
      fetched = 0;
      if (fb_access && !ack) discard_pend = 1;
    end
    if (fb_access && ack) begin
      req_open = 0;
      if (!rst_pos) begin
        if (discard_pend) discard_pend = 0;
        else begin
          wq.push_back(fb_data);
          fetched++;
        end
      end
    end
    k++;
    @(negedge clk);
  endtask

  initial begin
    int w;
    reset = 1'b1;
    fb_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_access", 32'(fb_access), 32'd0);
    chk("rst_addr", 32'(fb_address), 32'd0);
    chk("rst_hsync", 32'(vga_hsync), 32'd1);
    chk("rst_vsync", 32'(vga_vsync), 32'd1);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_idx", 32'(pix_idx), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_uf", 32'(underflow), 32'd0);

    reset = 1'b0;
    model_reset();
    repeat (3 * FRAME) step(0);
    chk("no_uf_full_rate", 32'(underflow), 32'd0);

    repeat (4 * FRAME) step(1);
    chk("uf_when_starved", 32'(underflow), 32'd1);

    fb_ack = 1'b0;
    w = 0;
    while (!fb_access && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("req_pending", 32'(fb_access), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_drop", 32'(fb_access), 32'd0);
    chk("rst_req_addr", 32'(fb_address), 32'd0);
    chk("rst_req_uf", 32'(underflow), 32'd0);
    // The first model step drives a late ack into the now-idle fetcher.
    reset = 1'b0;
    model_reset();
    repeat (2 * FRAME) step(0);
    chk("no_uf_after_rst", 32'(underflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
